pemcu_dbg_mailbox: RTL
======================

Name: pemcu_dbg_mailbox

Overview:
- Synthesizable XDATA slave on the PEMCU R8051XC2 memory bus. Decodes firmware debug-mailbox accesses at 16'hA100–16'hA10F plus a status byte at 16'hA110, and generates memack for them.
- Records every mailbox write (function code, params, POST code, mark, enter/return/fail/rule) as a timestamped entry in a trace FIFO.
- A host/debug port drains the FIFO, so silicon gets the same visibility that simulation-only monitoring provides.
- Sits directly on the bus path whose memack/memwr/memaddr/memdatao are the debug stream.

Parameters:
- FIFO_DEPTH, 16, trace entries; power of 2, ≥ 2.
- WAIT_STATES, 1, idle cycles between request sample and memack (0–7).
- TS_W, 20, free-running timestamp width.

Ports:
- clk  in  1  PEMCU core clock.
- rst_n  in  1  asynchronous active-low reset.
- memaddr  in  16  MCU XDATA address, stable while a request is high.
- memdatao  in  8  MCU write data.
- memwr  in  1  MCU write request; level, held until memack.
- memrd  in  1  MCU read request; level, held until memack.
- mbx_sel  out  1  combinational: memaddr in A100–A110.
- memack  out  1  one-cycle acknowledge for a selected access.
- memdatai  out  8  read data, valid in the memack cycle.
- trc_valid  out  1  FIFO non-empty.
- trc_data  out  TS_W+12  head entry {ts, reg_idx[3:0], data[7:0]}, show-ahead.
- trc_pop  in  1  consume head entry when trc_valid.
- trc_level  out  $clog2(FIFO_DEPTH)+1  entry count.
- trc_ovf  out  1  sticky: an entry was dropped.
- trc_clr  in  1  synchronous flush; also clears trc_ovf and drop_cnt.
- drop_cnt  out  8  dropped-entry count, saturates at 255.

Behaviour:
- Reset values: memack=0, memdatai=0, trc_valid=0, trc_level=0, trc_ovf=0, drop_cnt=0, timestamp=0. Shadow regs A100–A10F=0. FSM=IDLE.
- Timestamp increments every clk and wraps modulo 2^TS_W.
- FSM states:
  - IDLE: if mbx_sel & (memwr|memrd), latch addr, data, rd/wr; go to WAIT (or ACK if WAIT_STATES=0).
  - WAIT: count WAIT_STATES cycles, then go to ACK.
  - ACK: memack=1 for exactly one cycle, then IDLE. A new request is acceptable in the next cycle (back-to-back supported).
- If memwr and memrd are both high, treat as a write.
- Non-selected addresses: never ack, FSM stays IDLE.
- Write, in ACK cycle:
  - For A100–A10F, update shadow[idx] and push {ts_at_latch, idx, data}. Timestamp is sampled at the request-accept cycle.
  - A10C pushes with its written data; firmware writes 0.
  - Writes to A110 are ignored but still acked; no push.
- Read, in ACK cycle:
  - A100–A10F: memdatai = shadow[idx].
  - A110: memdatai = {trc_ovf, 2'b0, trc_level[4:0] saturated to 31}.
  - memdatai returns to 0 after ACK.
- FIFO full and push without pop: drop the entry, set trc_ovf, increment drop_cnt (saturating).
- Full with simultaneous push and pop: both execute, level unchanged, no drop.
- Empty with simultaneous push and pop: pop ignored, level becomes 1.
- trc_clr has priority over push and pop in the same cycle. A push coinciding with trc_clr is discarded without counting as a drop.
- Pointer wrap: pointers are $clog2(FIFO_DEPTH)+1 bits, compared including the MSB for full/empty.
- Async reset mid-transaction: memack drops immediately and the FSM returns to IDLE. The MCU re-issues the request, which must be acked normally.

Decomposition:
- Package pemcu_dbg_pkg:
  - MBX_BASE=16'hA100, MBX_STAT=16'hA110;
  - register index constants FUNC=0, PARA1..PARA8=1..8, POST=9, MARK=A, ENTER=B, RET=C, RETV=D, FAIL=E, RULE=F;
  - FSM state enum;
  - trace entry struct.
- Sub-module pemcu_dbg_fifo: synchronous show-ahead FIFO with push/pop/clr/level/full/empty, parameterized by width and depth.

Test Plan:
- Write 8'h04 to A100, WAIT_STATES=1 → memack exactly 2 cycles after request; trc_valid=1; trc_data={ts_at_accept, 4'h0, 8'h04}.
- Write A101=8'h11, A102=8'h22 back-to-back, then read A102 → memdatai=8'h22 in ack cycle; FIFO holds 3 entries in order, idx 0,1,2, non-decreasing ts.
- 17 writes with FIFO_DEPTH=16, no pops → trc_level=16, trc_ovf=1, drop_cnt=1; read A110 → 8'h90.
- FIFO full, simultaneous write-ack push and trc_pop → level stays 16, drop_cnt unchanged; then trc_clr → level 0, ovf 0, drop_cnt 0.
- Write to 16'hE000 → no memack and no push; memwr held 10 cycles, FSM stays IDLE.
- Assert rst_n low during WAIT → memack stays 0, FIFO empty; request held after reset release → acked after WAIT_STATES+1 cycles.

Source files
------------

// File: rtl/pemcu_dbg_mailbox_pkg.sv
// Shared constants and types for the PEMCU firmware debug mailbox.
// Address map, register indices, FSM states and the trace payload layout.
package pemcu_dbg_pkg;

  localparam logic [15:0] MBX_BASE = 16'hA100;
  localparam logic [15:0] MBX_STAT = 16'hA110;

  localparam logic [3:0] REG_FUNC  = 4'h0;
  localparam logic [3:0] REG_PARA1 = 4'h1;
  localparam logic [3:0] REG_PARA2 = 4'h2;
  localparam logic [3:0] REG_PARA3 = 4'h3;
  localparam logic [3:0] REG_PARA4 = 4'h4;
  localparam logic [3:0] REG_PARA5 = 4'h5;
  localparam logic [3:0] REG_PARA6 = 4'h6;
  localparam logic [3:0] REG_PARA7 = 4'h7;
  localparam logic [3:0] REG_PARA8 = 4'h8;
  localparam logic [3:0] REG_POST  = 4'h9;
  localparam logic [3:0] REG_MARK  = 4'hA;
  localparam logic [3:0] REG_ENTER = 4'hB;
  localparam logic [3:0] REG_RET   = 4'hC;
  localparam logic [3:0] REG_RETV  = 4'hD;
  localparam logic [3:0] REG_FAIL  = 4'hE;
  localparam logic [3:0] REG_RULE  = 4'hF;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_ACK
  } mbx_state_e;

  // Timestamp is prepended by the top because its width is a module parameter.
  typedef struct packed {
    logic [3:0] reg_idx;
    logic [7:0] data;
  } trc_payload_t;

  function automatic logic mbx_hit(input logic [15:0] addr);
    return (addr[15:4] == MBX_BASE[15:4]) || (addr == MBX_STAT);
  endfunction

endpackage

// File: rtl/pemcu_dbg_mailbox_fifo.sv
// Synchronous show-ahead FIFO holding mailbox trace entries.
// Latency: push visible on pop_dat the cycle after; pop consumes head at the edge.
// Backpressure: push refused when full unless a pop frees a slot; clr wins over both.
module pemcu_dbg_fifo #(
  parameter int W     = 32,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [W-1:0]             push_dat,
  input  logic                     pop,
  input  logic                     clr,
  output logic [W-1:0]             pop_dat,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     full,
  output logic                     empty
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW:0]   wr_ptr;
  logic [AW:0]   rd_ptr;
  logic          do_push;
  logic          do_pop;

  // Extra MSB on the pointers separates full from empty when the low bits match.
  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign level   = wr_ptr - rd_ptr;
  assign do_pop  = pop && !empty && !clr;
  assign do_push = push && (!full || do_pop) && !clr;
  assign pop_dat = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= push_dat;
  end

endmodule

// File: rtl/pemcu_dbg_mailbox.sv
// Debug-mailbox XDATA slave: acks A100-A110 and logs every register write as a timestamped trace entry.
// Latency: memack WAIT_STATES+1 cycles after the request is sampled; back-to-back requests accepted.
// Backpressure: trace FIFO drops entries when full (sticky trc_ovf, saturating drop_cnt); MCU is never stalled.
module pemcu_dbg_mailbox
  import pemcu_dbg_pkg::*;
#(
  parameter int FIFO_DEPTH  = 16,
  parameter int WAIT_STATES = 1,
  parameter int TS_W        = 20
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [15:0]                   memaddr,
  input  logic [7:0]                    memdatao,
  input  logic                          memwr,
  input  logic                          memrd,
  output logic                          mbx_sel,
  output logic                          memack,
  output logic [7:0]                    memdatai,
  output logic                          trc_valid,
  output logic [TS_W+11:0]              trc_data,
  input  logic                          trc_pop,
  output logic [$clog2(FIFO_DEPTH):0]   trc_level,
  output logic                          trc_ovf,
  input  logic                          trc_clr,
  output logic [7:0]                    drop_cnt
);

  localparam int ENT_W     = TS_W + 12;
  localparam int WAIT_LOAD = (WAIT_STATES > 0) ? WAIT_STATES - 1 : 0;

  mbx_state_e    state;
  logic [2:0]    wait_cnt;
  logic [3:0]    idx_q;
  logic          stat_q;
  logic          wr_q;
  logic [7:0]    data_q;
  logic [TS_W-1:0] ts_q;
  logic [TS_W-1:0] ts_cnt;
  logic [7:0]    shadow [16];

  logic [3:0]    acc_idx;
  logic          acc_stat;
  logic [7:0]    stat_byte;
  logic [7:0]    rd_byte;
  logic          push_req;
  logic          fifo_full;
  logic          fifo_empty;
  logic          drop;
  trc_payload_t  payload;

  assign mbx_sel = mbx_hit(memaddr);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ts_cnt <= '0;
    else        ts_cnt <= ts_cnt + 1'b1;
  end

  // With zero wait states the read mux must look at the live address, not the latched one.
  always_comb begin
    acc_idx   = (state == ST_IDLE) ? memaddr[3:0] : idx_q;
    acc_stat  = (state == ST_IDLE) ? memaddr[4]   : stat_q;
    stat_byte = {trc_ovf, 2'b00, 5'd31};
    if (int'(trc_level) < 32) stat_byte[4:0] = 5'(trc_level);
    rd_byte   = acc_stat ? stat_byte : shadow[acc_idx];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      wait_cnt <= '0;
      idx_q    <= '0;
      stat_q   <= 1'b0;
      wr_q     <= 1'b0;
      data_q   <= '0;
      ts_q     <= '0;
      memack   <= 1'b0;
      memdatai <= '0;
    end else begin
      memack   <= 1'b0;
      memdatai <= '0;
      case (state)
        ST_IDLE: begin
          if (mbx_sel && (memwr || memrd)) begin
            idx_q  <= memaddr[3:0];
            stat_q <= memaddr[4];
            wr_q   <= memwr;
            data_q <= memdatao;
            ts_q   <= ts_cnt;
            if (WAIT_STATES == 0) begin
              state  <= ST_ACK;
              memack <= 1'b1;
              if (!memwr) memdatai <= rd_byte;
            end else begin
              state    <= ST_WAIT;
              wait_cnt <= 3'(WAIT_LOAD);
            end
          end
        end
        ST_WAIT: begin
          if (wait_cnt == 3'd0) begin
            state  <= ST_ACK;
            memack <= 1'b1;
            if (!wr_q) memdatai <= rd_byte;
          end else begin
            wait_cnt <= wait_cnt - 1'b1;
          end
        end
        ST_ACK:  state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign push_req = (state == ST_ACK) && wr_q && !stat_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 16; i++) shadow[i] <= '0;
    end else if (push_req) begin
      shadow[idx_q] <= data_q;
    end
  end

  assign payload = '{reg_idx: idx_q, data: data_q};

  pemcu_dbg_fifo #(
    .W     (ENT_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .push     (push_req),
    .push_dat ({ts_q, payload}),
    .pop      (trc_pop),
    .clr      (trc_clr),
    .pop_dat  (trc_data),
    .level    (trc_level),
    .full     (fifo_full),
    .empty    (fifo_empty)
  );

  assign trc_valid = !fifo_empty;

  // A pop in the same cycle frees a slot, so only an unmatched push into a full FIFO is lost.
  assign drop = push_req && fifo_full && !trc_pop && !trc_clr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      trc_ovf  <= 1'b0;
      drop_cnt <= '0;
    end else if (trc_clr) begin
      trc_ovf  <= 1'b0;
      drop_cnt <= '0;
    end else if (drop) begin
      trc_ovf <= 1'b1;
      if (drop_cnt != 8'hFF) drop_cnt <= drop_cnt + 1'b1;
    end
  end

endmodule
